// File: rtl/sum_pkg.sv
// Shared types and constants for the sum sequencer: FSM states, the default
// sum datapath latency and the 2-bit operand/result type.
package sum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int SUM_LATENCY_DEF = 3;

    typedef logic [1:0] sum2_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sum_sequencer_if.sv
// Requester/consumer handshake bundle of the sum sequencer.
// slave: the sequencer side; master: requesters and response consumer.
interface sum_sequencer_if import sum_pkg::*; #(
    parameter int N_REQ = 2
);

    localparam int IDX_W = idx_width(N_REQ);

    logic [N_REQ-1:0]   i_req_valid;
    logic [2*N_REQ-1:0] i_req_sw;
    logic [N_REQ-1:0]   o_req_ready;
    logic               o_rsp_valid;
    logic [IDX_W-1:0]   o_rsp_id;
    sum2_t              o_rsp_led;
    logic               i_rsp_ready;

    modport slave (
        input  i_req_valid, i_req_sw, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_led
    );

    modport master (
        output i_req_valid, i_req_sw, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_led
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the requester after the last
// granted one; the pointer only moves when the grant is actually taken.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_advance,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] idx_s;

    // Walk from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        o_grant_idx = '0;
        idx_s       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx_s       = IDX_W'((int'(ptr_q) + i) % N_REQ);
            o_grant_idx = i_req[idx_s] ? idx_s : o_grant_idx;
        end
        o_grant = (|i_req) ? (N_REQ'(1) << o_grant_idx) : '0;
    end

    // Next pointer: one past the granted requester, wrapping to zero.
    always_comb begin
        ptr_d = ptr_q;
        if (i_advance) begin
            ptr_d = (o_grant_idx == IDX_W'(N_REQ - 1)) ? '0 : o_grant_idx + IDX_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register; reset gives requester 0 top priority.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sum_sequencer.sv
// Sum sequencer: arbitrates N_REQ requesters onto one external sum datapath,
// waits out its latency, then holds the result until the consumer takes it.
module sum_sequencer import sum_pkg::*; #(
    parameter int N_REQ       = 2,
    parameter int SUM_LATENCY = SUM_LATENCY_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst,
    sum_sequencer_if.slave bus,
    output sum2_t          o_sum_sw,
    input  sum2_t          i_sum_led,
    output logic           o_busy,
    output logic [7:0]     o_done_cnt
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = $clog2(SUM_LATENCY + 1) + 1;

    state_e           state_q, state_d;
    sum2_t            sum_sw_q, sum_sw_d;
    sum2_t            rsp_led_q, rsp_led_d;
    logic [IDX_W-1:0] rsp_id_q, rsp_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
    logic [7:0]       done_cnt_q, done_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] grant_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic             accept_en_s;
    logic             handshake_s;
    sum2_t            operand_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (bus.i_req_valid),
        .i_advance   (handshake_s),
        .o_grant     (grant_s),
        .o_grant_idx (grant_idx_s)
    );

    // Ready is only offered in IDLE and never while reset is applied.
    always_comb begin
        accept_en_s     = (state_q == IDLE) && !i_rst;
        bus.o_req_ready = accept_en_s ? grant_s : '0;
        handshake_s     = accept_en_s && (|grant_s);
        operand_s       = sum2_t'(bus.i_req_sw >> {grant_idx_s, 1'b0});
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d    = state_q;
        sum_sw_d   = sum_sw_q;
        rsp_led_d  = rsp_led_q;
        rsp_id_d   = rsp_id_q;
        done_cnt_d = done_cnt_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (handshake_s) begin
                    sum_sw_d = operand_s;
                    rsp_id_d = grant_idx_s;
                    cnt_d    = CNT_W'(SUM_LATENCY);
                    state_d  = WAIT;
                end else begin
                    state_d  = IDLE;
                end
            end
            WAIT: begin
                // Counter runs SUM_LATENCY..0, giving SUM_LATENCY+1 WAIT cycles.
                if (cnt_q == '0) begin
                    rsp_led_d = i_sum_led;
                    state_d   = RESP;
                end else begin
                    cnt_d     = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.i_rsp_ready) begin
                    done_cnt_d = done_cnt_q + 8'd1;
                    state_d    = IDLE;
                end else begin
                    state_d    = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            sum_sw_q    <= 2'd0;
            rsp_led_q   <= 2'd0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_cnt_q  <= 8'd0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sum_sw_q    <= sum_sw_d;
            rsp_led_q   <= rsp_led_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            done_cnt_q  <= done_cnt_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_sum_sw        = sum_sw_q;
    assign o_busy          = busy_q;
    assign o_done_cnt      = done_cnt_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_id    = rsp_id_q;
    assign bus.o_rsp_led   = rsp_led_q;

endmodule

// File: tb/tb_sum_sequencer.sv
// Self-checking bench for sum_sequencer: table of single operations, directed
// multi-cycle sequences and randomized traffic against a transaction model.
module tb_sum_sequencer;

    logic       clk;
    logic       i_rst;
    logic [1:0] o_sum_sw;
    logic [1:0] i_sum_led;
    logic       o_busy;
    logic [7:0] o_done_cnt;
    logic       sum_rst_n;
    logic [1:0] p1, p2, p3;

    sum_sequencer_if #(.N_REQ(2)) bus_if();

    sum_sequencer #(.N_REQ(2), .SUM_LATENCY(3)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .bus        (bus_if),
        .o_sum_sw   (o_sum_sw),
        .i_sum_led  (i_sum_led),
        .o_busy     (o_busy),
        .o_done_cnt (o_done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External sum datapath: three register stages, active-low reset.
    assign sum_rst_n = ~i_rst;
    always @(posedge clk) begin
        if (!sum_rst_n) begin
            p1 <= 2'd0; p2 <= 2'd0; p3 <= 2'd0;
        end else begin
            p1 <= o_sum_sw; p2 <= p1; p3 <= p2;
        end
    end
    assign i_sum_led = {1'b0, p3[1]} + {1'b0, p3[0]};

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Transaction-level reference state.
    bit m_out;
    int m_hs, m_id, m_led, m_last, m_done, m_sw;

    // Values seen at the latest sample point.
    logic [1:0] s_ready;
    logic       s_rsp_valid;
    int         s_rsp_id, s_rsp_led;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit hit(input logic [1:0] r, input int k);
        return ((int'(r) >> k) & 1) == 1;
    endfunction

    // One clock: drive inputs at negedge, sample just after, compare to model.
    task automatic step(input logic rst, input logic [1:0] v, input logic [3:0] sw, input logic rr);
        logic [1:0] exp_ready;
        int ch;
        bit exp_rv;
        @(negedge clk);
        i_rst = rst;
        bus_if.i_req_valid = v;
        bus_if.i_req_sw    = sw;
        bus_if.i_rsp_ready = rr;
        #1;
        cyc++;
        s_ready     = bus_if.o_req_ready;
        s_rsp_valid = bus_if.o_rsp_valid;
        s_rsp_id    = int'(bus_if.o_rsp_id);
        s_rsp_led   = int'(bus_if.o_rsp_led);
        if (rst) begin
            chk("ready_in_reset", 32'(s_ready), 32'd0);
            m_out = 1'b0; m_last = 1; m_done = 0; m_sw = 0;
        end else begin
            ch = -1;
            if (!m_out) begin
                for (int off = 1; off <= 2; off++) begin
                    if (ch < 0 && hit(v, (m_last + off) % 2)) ch = (m_last + off) % 2;
                end
            end
            exp_ready = (ch >= 0) ? 2'(1 << ch) : 2'b00;
            exp_rv = m_out && (cyc - m_hs >= 5);
            chk("ready", 32'(s_ready), 32'(exp_ready));
            chk("busy", 32'(o_busy), 32'(m_out));
            chk("rsp_valid", 32'(s_rsp_valid), 32'(exp_rv));
            chk("sum_sw", 32'(o_sum_sw), 32'(m_sw));
            chk("done_cnt", 32'(o_done_cnt), 32'(m_done));
            if (exp_rv) begin
                chk("rsp_id", 32'(s_rsp_id), 32'(m_id));
                chk("rsp_led", 32'(s_rsp_led), 32'(m_led));
            end
            if (exp_rv && rr) begin
                m_out = 1'b0;
                m_done = (m_done + 1) % 256;
            end else if (ch >= 0) begin
                m_out = 1'b1; m_hs = cyc; m_id = ch; m_last = ch;
                m_sw = (int'(sw) >> (2 * ch)) % 4;
                m_led = (m_sw / 2) + (m_sw % 2);
            end
        end
    endtask

    // One complete operation from requester k alone; consumer always ready.
    task automatic do_op(input int k, input logic [1:0] sw, output int got_id, output int got_led, output int lat);
        logic [1:0] v;
        logic [3:0] s;
        int n;
        v = 2'(1 << k);
        s = 4'(int'(sw) << (2 * k));
        n = 0;
        step(1'b0, v, s, 1'b0);
        while (!hit(s_ready, k) && n < 20) begin
            step(1'b0, v, s, 1'b0);
            n++;
        end
        chk("op_grant", 32'(hit(s_ready, k)), 32'd1);
        lat = 0;
        do begin
            step(1'b0, 2'b00, 4'b0000, 1'b1);
            lat++;
        end while (!s_rsp_valid && lat < 20);
        got_id = s_rsp_id;
        got_led = s_rsp_led;
    endtask

    typedef struct {
        int         k;
        logic [1:0] sw;
        int         exp_id;
        int         exp_led;
    } vec_t;

    vec_t tbl[5];
    int   gid, gled, glat, n, ng, nr, done0, id0, led0, cnt_v;
    int   gord[4], res[4];
    int   exp_g[4] = '{0, 1, 0, 1};
    int   exp_r[4] = '{1, 0, 1, 0};
    bit   pend[2];
    int   psw[2];
    logic [1:0] rv;
    logic [3:0] rs;
    logic rrst, rrdy;

    initial begin
        i_rst = 1'b1;
        bus_if.i_req_valid = 2'b00;
        bus_if.i_req_sw    = 4'b0000;
        bus_if.i_rsp_ready = 1'b0;
        tbl[0] = '{0, 2'b11, 0, 2};
        tbl[1] = '{1, 2'b00, 1, 0};
        tbl[2] = '{1, 2'b01, 1, 1};
        tbl[3] = '{1, 2'b10, 1, 1};
        tbl[4] = '{1, 2'b11, 1, 2};

        step(1'b1, 2'b00, 4'b0000, 1'b0);
        step(1'b1, 2'b00, 4'b0000, 1'b0);
        step(1'b0, 2'b00, 4'b0000, 1'b0);
        chk("reset_rsp_valid", 32'(s_rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(s_rsp_id), 32'd0);
        chk("reset_rsp_led", 32'(s_rsp_led), 32'd0);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_sum_sw", 32'(o_sum_sw), 32'd0);

        // Table of single operations: result value, owner and latency.
        for (int i = 0; i < 5; i++) begin
            do_op(tbl[i].k, tbl[i].sw, gid, gled, glat);
            chk("tbl_id", 32'(gid), 32'(tbl[i].exp_id));
            chk("tbl_led", 32'(gled), 32'(tbl[i].exp_led));
            chk("tbl_latency", 32'(glat), 32'd5);
        end

        // Contention: both requesters valid throughout.
        step(1'b1, 2'b00, 4'b0000, 1'b0);
        ng = 0; nr = 0; n = 0;
        for (int i = 0; i < 4; i++) begin gord[i] = -1; res[i] = -1; end
        while ((ng < 4 || nr < 4) && n < 60) begin
            step(1'b0, 2'b11, 4'b0001, 1'b1);
            n++;
            if (s_ready != 2'b00 && ng < 4) begin gord[ng] = hit(s_ready, 1) ? 1 : 0; ng++; end
            if (s_rsp_valid && nr < 4) begin res[nr] = s_rsp_led; nr++; end
        end
        for (int i = 0; i < 4; i++) begin
            chk("cont_grant_order", 32'(gord[i]), 32'(exp_g[i]));
            chk("cont_result", 32'(res[i]), 32'(exp_r[i]));
        end

        // Backpressure: response held while the consumer stalls.
        step(1'b1, 2'b00, 4'b0000, 1'b0);
        step(1'b0, 2'b01, 4'b0010, 1'b0);
        n = 0;
        while (!s_rsp_valid && n < 20) begin
            step(1'b0, 2'b10, 4'b0100, 1'b0);
            n++;
        end
        chk("bp_rsp_arrives", 32'(s_rsp_valid), 32'd1);
        id0 = s_rsp_id; led0 = s_rsp_led; done0 = int'(o_done_cnt);
        chk("bp_led_value", 32'(led0), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'b10, 4'b0100, 1'b0);
            chk("bp_no_grant", 32'(s_ready), 32'd0);
            chk("bp_valid_held", 32'(s_rsp_valid), 32'd1);
            chk("bp_id_held", 32'(s_rsp_id), 32'(id0));
            chk("bp_led_held", 32'(s_rsp_led), 32'(led0));
            chk("bp_done_held", 32'(o_done_cnt), 32'(done0));
        end
        step(1'b0, 2'b10, 4'b0100, 1'b1);
        step(1'b0, 2'b10, 4'b0100, 1'b0);
        chk("bp_done_once", 32'(o_done_cnt), 32'((done0 + 1) % 256));
        chk("bp_stalled_req_granted", 32'(s_ready), 32'd2);

        // Reset pulse in the middle of WAIT aborts the operation.
        step(1'b1, 2'b00, 4'b0000, 1'b0);
        do_op(0, 2'b11, gid, gled, glat);
        step(1'b0, 2'b01, 4'b0011, 1'b0);
        chk("rw_handshake", 32'(s_ready), 32'd1);
        step(1'b0, 2'b00, 4'b0000, 1'b0);
        step(1'b0, 2'b00, 4'b0000, 1'b0);
        step(1'b1, 2'b00, 4'b0000, 1'b1);
        step(1'b0, 2'b00, 4'b0000, 1'b1);
        chk("rw_busy", 32'(o_busy), 32'd0);
        chk("rw_rsp_valid", 32'(s_rsp_valid), 32'd0);
        chk("rw_rsp_id", 32'(s_rsp_id), 32'd0);
        chk("rw_rsp_led", 32'(s_rsp_led), 32'd0);
        chk("rw_sum_sw", 32'(o_sum_sw), 32'd0);
        chk("rw_done_cnt", 32'(o_done_cnt), 32'd0);
        cnt_v = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 2'b00, 4'b0000, 1'b1);
            if (s_rsp_valid) cnt_v++;
        end
        chk("rw_no_response", 32'(cnt_v), 32'd0);

        // Completion counter wraps after 256 operations.
        step(1'b1, 2'b00, 4'b0000, 1'b0);
        for (int i = 0; i < 256; i++) begin
            do_op(i % 2, 2'(i % 4), gid, gled, glat);
            if (i == 254) begin
                step(1'b0, 2'b00, 4'b0000, 1'b0);
                chk("wrap_255", 32'(o_done_cnt), 32'd255);
            end
        end
        step(1'b0, 2'b00, 4'b0000, 1'b0);
        chk("wrap_zero", 32'(o_done_cnt), 32'd0);

        // Randomized traffic: requesters hold until granted, random consumer.
        step(1'b1, 2'b00, 4'b0000, 1'b0);
        pend[0] = 1'b0; pend[1] = 1'b0; psw[0] = 0; psw[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            rv = {pend[1], pend[0]};
            rs = 4'((psw[1] << 2) | psw[0]);
            rrdy = ($urandom_range(0, 9) < 6);
            rrst = ($urandom_range(0, 399) == 0);
            step(rrst, rv, rs, rrdy);
            for (int k = 0; k < 2; k++) begin
                if (!rrst && hit(s_ready, k)) pend[k] = 1'b0;
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k] = 1'b1;
                    psw[k] = int'($urandom_range(0, 3));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
